// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline boundary as a 2-entry valid/ready skid buffer.
// Memory/writeback control is gated on bubbles; fwd_valid qualifies forwarding.
module ex_mem_skid_reg #(
  parameter int DATA_W       = 32,
  parameter int RA_W         = 5,
  parameter int WB_W         = 2,
  parameter int REGWRITE_BIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [1:0]        m_in,
  input  logic              alu_zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [RA_W-1:0]   rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic              mem_write,
  output logic              mem_read,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [RA_W-1:0]   rd_out,
  output logic              fwd_valid,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [1:0]        m;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [RA_W-1:0]   rd;
  } entry_t;

  state_t state_r;
  entry_t head_r;
  entry_t skid_r;
  entry_t in_entry_s;
  logic   push_s;
  logic   pop_s;

  assign in_entry_s = '{wb: wb_in, m: m_in, zero: alu_zero_in, alu: alu_result_in,
                        store: store_data_in, rd: rd_in};

  // in_ready depends on state only so the upstream path never sees out_ready
  assign in_ready  = (state_r != TWO);
  assign out_valid = (state_r != EMPTY);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign occupancy = state_r;

  // State and entry storage; the head entry always drives the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      head_r  <= '0;
      skid_r  <= '0;
    end else if (flush) begin
      state_r <= EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            head_r  <= in_entry_s;
            state_r <= ONE;
          end
        end
        ONE: begin
          if (push_s && !pop_s) begin
            skid_r  <= in_entry_s;
            state_r <= TWO;
          end else if (push_s && pop_s) begin
            head_r  <= in_entry_s;
          end else if (pop_s) begin
            state_r <= EMPTY;
          end
        end
        TWO: begin
          if (pop_s) begin
            head_r  <= skid_r;
            state_r <= ONE;
          end
        end
        default: state_r <= EMPTY;
      endcase
    end
  end

  // Bubbles must never write memory or the register file
  assign wb_out         = out_valid ? head_r.wb : {WB_W{1'b0}};
  assign mem_write      = out_valid & head_r.m[0];
  assign mem_read       = out_valid & head_r.m[1];
  assign zero_out       = head_r.zero;
  assign alu_result_out = head_r.alu;
  assign store_data_out = head_r.store;
  assign rd_out         = head_r.rd;
  assign fwd_valid      = out_valid & head_r.wb[REGWRITE_BIT] & (head_r.rd != {RA_W{1'b0}});

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg with hand-computed expectations.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  wb_in, m_in, wb_out, occupancy;
  logic        alu_zero_in, mem_write, mem_read, zero_out, fwd_valid;
  logic [31:0] alu_result_in, store_data_in, alu_result_out, store_data_out;
  logic [4:0]  rd_in, rd_out;
  int          checks = 0;
  int          errors = 0;

  ex_mem_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_in(wb_in), .m_in(m_in), .alu_zero_in(alu_zero_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
    .wb_out(wb_out), .mem_write(mem_write), .mem_read(mem_read), .zero_out(zero_out),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_out(rd_out),
    .fwd_valid(fwd_valid), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_in = 2'b00; m_in = 2'b00; alu_zero_in = 1'b0;
    alu_result_in = 32'h0; store_data_in = 32'h0; rd_in = 5'd0;
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_wb_out", wb_out, 2'b00);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_alu", alu_result_out, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Streaming
    out_ready = 1'b1; in_valid = 1'b1; alu_result_in = 32'h10; store_data_in = 32'h111;
    tick();
    chk("s1_alu", alu_result_out, 32'h10);
    chk("s1_store", store_data_out, 32'h111);
    chk("s1_occ", occupancy, 2'd1);
    chk("s1_zero", zero_out, 1'b0);
    alu_result_in = 32'h20; alu_zero_in = 1'b1;
    tick();
    chk("s2_alu", alu_result_out, 32'h20);
    chk("s2_occ", occupancy, 2'd1);
    chk("s2_zero", zero_out, 1'b1);
    alu_result_in = 32'h30; alu_zero_in = 1'b0;
    tick();
    chk("s3_alu", alu_result_out, 32'h30);
    chk("s3_zero", zero_out, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("s4_out_valid", out_valid, 1'b0);
    chk("s4_occ", occupancy, 2'd0);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; alu_result_in = 32'hAAAA;
    tick();
    chk("bp1_occ", occupancy, 2'd1);
    chk("bp1_alu", alu_result_out, 32'hAAAA);
    alu_result_in = 32'hBBBB;
    tick();
    chk("bp2_occ", occupancy, 2'd2);
    chk("bp2_in_ready", in_ready, 1'b0);
    chk("bp2_alu", alu_result_out, 32'hAAAA);
    in_valid = 1'b0;
    tick();
    chk("bp3_alu_hold", alu_result_out, 32'hAAAA);
    chk("bp3_occ", occupancy, 2'd2);
    out_ready = 1'b1;
    #1;
    chk("bp3_in_ready_indep", in_ready, 1'b0);
    tick();
    chk("bp4_alu", alu_result_out, 32'hBBBB);
    chk("bp4_occ", occupancy, 2'd1);
    tick();
    chk("bp5_out_valid", out_valid, 1'b0);

    // Flush with two entries plus a push attempt
    out_ready = 1'b0; in_valid = 1'b1; m_in = 2'b01; wb_in = 2'b01; rd_in = 5'd3;
    alu_result_in = 32'h1;
    tick();
    chk("fl1_mem_write", mem_write, 1'b1);
    chk("fl1_fwd", fwd_valid, 1'b1);
    alu_result_in = 32'h2;
    tick();
    chk("fl2_occ", occupancy, 2'd2);
    alu_result_in = 32'hDEAD; flush = 1'b1;
    tick();
    chk("fl3_occ", occupancy, 2'd0);
    chk("fl3_mem_write", mem_write, 1'b0);
    chk("fl3_fwd", fwd_valid, 1'b0);
    chk("fl3_wb_out", wb_out, 2'b00);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl4_out_valid", out_valid, 1'b0);
    chk("fl4_occ", occupancy, 2'd0);

    // Forwarding qualifier and memory control decode
    m_in = 2'b00; wb_in = 2'b01; rd_in = 5'd0; in_valid = 1'b1; alu_result_in = 32'h44;
    tick();
    chk("fw1_fwd", fwd_valid, 1'b0);
    chk("fw1_wb_out", wb_out, 2'b01);
    rd_in = 5'd7;
    tick();
    chk("fw2_fwd", fwd_valid, 1'b1);
    chk("fw2_rd", rd_out, 5'd7);
    m_in = 2'b10;
    tick();
    chk("fw3_mem_read", mem_read, 1'b1);
    chk("fw3_mem_write", mem_write, 1'b0);
    wb_in = 2'b00;
    tick();
    chk("fw4_fwd_noregwrite", fwd_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("fw5_mem_read_gated", mem_read, 1'b0);
    chk("fw5_wb_gated", wb_out, 2'b00);
    chk("fw5_fwd_gated", fwd_valid, 1'b0);

    // Async reset mid-cycle with two entries held
    out_ready = 1'b0; in_valid = 1'b1; m_in = 2'b01; wb_in = 2'b01; rd_in = 5'd5;
    alu_result_in = 32'h55;
    tick();
    alu_result_in = 32'h66;
    tick();
    in_valid = 1'b0;
    chk("ar0_occ", occupancy, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_occ", occupancy, 2'd0);
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_mem_write", mem_write, 1'b0);
    chk("ar_wb_out", wb_out, 2'b00);
    chk("ar_fwd", fwd_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_alu", alu_result_out, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_after_occ", occupancy, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Parametrised EX/MEM pipeline boundary register.
- Sits between the ALU stage and the data-memory stage.
- Replaces a bare always-load flop stage with a 2-entry elastic (skid) buffer using a valid/ready handshake, plus a synchronous flush.
- Gates memory and writeback control on invalid (bubble) slots, and exports a forwarding-qualifier for the hazard unit.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- RA_W, 5, destination register address width.
- WB_W, 2, writeback control bundle width.
- REGWRITE_BIT, 0, index within wb_in/wb_out of the register-write enable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush of all buffered entries.
- in_valid  in  1  EX stage presents a valid instruction.
- in_ready  out  1  block can accept this cycle.
- wb_in  in  WB_W  writeback control.
- m_in  in  2  memory control; [0]=mem_write, [1]=mem_read.
- alu_zero_in  in  1  ALU zero flag.
- alu_result_in  in  DATA_W  ALU result / memory address.
- store_data_in  in  DATA_W  store data (forwarded rt value).
- rd_in  in  RA_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM stage consumes head this cycle.
- wb_out  out  WB_W  head writeback control, gated.
- mem_write  out  1  head mem_write, gated.
- mem_read  out  1  head mem_read, gated.
- zero_out  out  1  head zero flag.
- alu_result_out  out  DATA_W  head ALU result.
- store_data_out  out  DATA_W  head store data.
- rd_out  out  RA_W  head destination register.
- fwd_valid  out  1  out_valid & wb_out[REGWRITE_BIT] & (rd_out != 0).
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: head register (drives outputs) and skid register. State is one of EMPTY, ONE or TWO; occupancy encodes 0/1/2.
- Reset (rst_n=0, asynchronous):
  - state EMPTY; both entries' fields cleared to 0.
  - All outputs read 0 except in_ready, which reads 1.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (state != TWO), combinational from state only; it does not depend on out_ready.
  - out_valid = (state != EMPTY).
- Transitions (flush=0):
  - EMPTY: push → load head, go ONE.
  - ONE:
    - push & !pop → load skid, go TWO.
    - push & pop → load head with new data, stay ONE.
    - pop only → EMPTY.
    - neither → hold.
  - TWO:
    - pop → head ← skid, go ONE.
    - otherwise hold. No push is possible because in_ready=0.
- Latency: an entry pushed into EMPTY is visible on outputs the cycle after acceptance. Entries leave in FIFO order.
- Payload: all input fields are captured verbatim. zero_out carries alu_zero_in; it is never forced to a constant.
- Gating: when out_valid=0, wb_out, mem_write, mem_read and fwd_valid are forced to 0. alu_result_out, store_data_out, rd_out and zero_out hold stale contents and are don't-care.
- Flush:
  - flush=1 at an edge → state EMPTY regardless of push/pop.
  - A simultaneous push is discarded; a pop that cycle is still considered completed by MEM.
  - Data fields need not be cleared.
- Hold: while out_ready=0, head outputs stay bit-stable.
- Reset mid-operation: buffered entries are lost immediately; no partial update occurs.

Test Plan:
- Reset → out_valid=0, mem_write=0, mem_read=0, wb_out=0, occupancy=0, in_ready=1.
- Streaming with out_ready=1: push alu_result 0x10, 0x20, 0x30 on consecutive cycles → same values at output one cycle later each; occupancy stays 1; alu_zero_in=1 on 0x20 → zero_out=1 in that cycle.
- Backpressure: out_ready=0, push A=0xAAAA then B=0xBBBB → occupancy=2, in_ready=0, output stable at A. Release out_ready → A then B, then out_valid=0.
- Flush with occupancy=2 plus push attempt → next cycle occupancy=0, mem_write=0, fwd_valid=0; pushed entry never appears.
- Forwarding: wb_in=2'b01, rd_in=0 → fwd_valid=0; rd_in=7 → fwd_valid=1, rd_out=7; m_in=2'b10 → mem_read=1, mem_write=0.
- Async reset asserted mid-cycle with occupancy=2 → outputs clear immediately, without waiting for a clk edge.
